// File: rtl/mdu_seq_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer for the EX stage, producing the HI/LO pair.
// Optional: define MDU_FAST_MULT_EN to compute multiplies combinationally in PREP.
module mdu_seq_ctrl #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              flush,
    output logic              stall,
    output logic              done,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    output logic              div_by_zero
);

    typedef enum logic [2:0] {StIdle, StPrep, StCalc, StFix, StDone} state_e;

    localparam logic [CNT_W-1:0] CntInit = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

    state_e              state_q;
    logic [1:0]          op_q;
    logic [DATA_W-1:0]   a_q, b_q, opnd_q;
    logic [2*DATA_W-1:0] acc_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                neg_quo_q, neg_rem_q;

    logic                is_div, is_signed;
    logic [DATA_W-1:0]   a_mag, b_mag, quo_fix, rem_fix;
    logic [DATA_W:0]     mul_sum, div_shift, div_diff;
    logic [2*DATA_W-1:0] acc_step, mul_fix;

    always_comb begin
        is_div    = op_q[1];
        is_signed = ~op_q[0];
        a_mag     = (is_signed && a_q[DATA_W-1]) ? -a_q : a_q;
        b_mag     = (is_signed && b_q[DATA_W-1]) ? -b_q : b_q;

        // Multiply: add multiplicand into the upper half when the current LSB is set, then shift.
        mul_sum   = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + {1'b0, (acc_q[0] ? opnd_q : '0)};
        // Divide: upper half is the partial remainder, lower half shifts dividend out / quotient in.
        div_shift = {acc_q[2*DATA_W-1:DATA_W], acc_q[DATA_W-1]};
        div_diff  = div_shift - {1'b0, opnd_q};

        if (is_div) begin
            acc_step = div_diff[DATA_W] ? {div_shift[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b0}
                                        : {div_diff[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b1};
        end else begin
            acc_step = {mul_sum, acc_q[DATA_W-1:1]};
        end

        mul_fix = neg_quo_q ? -acc_q : acc_q;
        quo_fix = neg_quo_q ? -acc_q[DATA_W-1:0] : acc_q[DATA_W-1:0];
        rem_fix = neg_rem_q ? -acc_q[2*DATA_W-1:DATA_W] : acc_q[2*DATA_W-1:DATA_W];

        stall = ((state_q == StIdle) && start) || (state_q == StPrep) ||
                (state_q == StCalc) || (state_q == StFix);
    end

`ifdef MDU_FAST_MULT_EN
    logic [2*DATA_W-1:0] a_ext, b_ext, prod_fast;

    // Low 2*DATA_W bits of the product of sign-extended operands equal the signed product.
    always_comb begin
        a_ext     = {{DATA_W{is_signed & a_q[DATA_W-1]}}, a_q};
        b_ext     = {{DATA_W{is_signed & b_q[DATA_W-1]}}, b_q};
        prod_fast = a_ext * b_ext;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            opnd_q      <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else if (flush) begin
            state_q <= StIdle;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        op_q        <= op;
                        a_q         <= a;
                        b_q         <= b;
                        div_by_zero <= 1'b0;
                        state_q     <= StPrep;
                    end
                end
                StPrep: begin
                    neg_quo_q <= is_signed & (a_q[DATA_W-1] ^ b_q[DATA_W-1]);
                    neg_rem_q <= is_signed & a_q[DATA_W-1];
                    cnt_q     <= CntInit;
                    if (is_div && (b_q == '0)) begin
                        hi          <= a_q;
                        lo          <= '1;
                        div_by_zero <= 1'b1;
                        done        <= 1'b1;
                        state_q     <= StDone;
                    end
`ifdef MDU_FAST_MULT_EN
                    else if (!is_div) begin
                        hi      <= prod_fast[2*DATA_W-1:DATA_W];
                        lo      <= prod_fast[DATA_W-1:0];
                        done    <= 1'b1;
                        state_q <= StDone;
                    end
`endif
                    else begin
                        acc_q   <= {{DATA_W{1'b0}}, (is_div ? a_mag : b_mag)};
                        opnd_q  <= is_div ? b_mag : a_mag;
                        state_q <= StCalc;
                    end
                end
                StCalc: begin
                    acc_q <= acc_step;
                    cnt_q <= cnt_q - CntOne;
                    if (cnt_q == CntOne) begin
                        state_q <= StFix;
                    end
                end
                StFix: begin
                    if (is_div) begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end else begin
                        hi <= mul_fix[2*DATA_W-1:DATA_W];
                        lo <= mul_fix[DATA_W-1:0];
                    end
                    done    <= 1'b1;
                    state_q <= StDone;
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_seq_ctrl.sv
// Self-checking bench for mdu_seq_ctrl: directed and random ops against an arithmetic model.
module tb_mdu_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst, start, flush;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        stall, done, div_by_zero;
    logic [31:0] hi, lo;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] last_hi = '0;
    logic [31:0] last_lo = '0;

    always #5 clk = ~clk;

    mdu_seq_ctrl #(
        .DATA_W(32),
        .CNT_W (6)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .op         (op),
        .a          (a),
        .b          (b),
        .flush      (flush),
        .stall      (stall),
        .done       (done),
        .hi         (hi),
        .lo         (lo),
        .div_by_zero(div_by_zero)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference arithmetic: MIPS semantics, truncating division, remainder takes dividend sign.
    task automatic model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] eh, output logic [31:0] el, output logic ez);
        longint          p, q, r;
        longint unsigned pu;
        ez = 1'b0;
        case (o)
            2'd0: begin
                p  = longint'($signed(x)) * longint'($signed(y));
                eh = p[63:32];
                el = p[31:0];
            end
            2'd1: begin
                pu = {32'h0, x} * {32'h0, y};
                eh = pu[63:32];
                el = pu[31:0];
            end
            default: begin
                if (y == 32'h0) begin
                    eh = x;
                    el = 32'hFFFF_FFFF;
                    ez = 1'b1;
                end else if (o == 2'd2) begin
                    q  = longint'($signed(x)) / longint'($signed(y));
                    r  = longint'($signed(x)) % longint'($signed(y));
                    eh = r[31:0];
                    el = q[31:0];
                end else begin
                    eh = x % y;
                    el = x / y;
                end
            end
        endcase
    endtask

    function automatic int exp_lat(input logic [1:0] o, input logic [31:0] y);
        if (o[1] && (y == 32'h0)) return 2;
`ifdef MDU_FAST_MULT_EN
        if (!o[1]) return 2;
`endif
        return 35;
    endfunction

    // Issue one op from IDLE and follow it to its done pulse; spam keeps start busy with junk.
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input bit spam);
        logic [31:0] eh, el;
        logic        ez;
        int          lat, stalls, want;
        model(o, x, y, eh, el, ez);
        want = exp_lat(o, y);
        check("idle_stall", 64'(stall), 64'd0);
        start = 1'b1; op = o; a = x; b = y;
        #1;
        check("start_stall", 64'(stall), 64'd1);
        tick();
        start = spam;
        lat = 1;
        stalls = 1;
        check("hold_hi", 64'(hi), 64'(last_hi));
        check("hold_lo", 64'(lo), 64'(last_lo));
        check("dbz_clear", 64'(div_by_zero), 64'd0);
        while (done !== 1'b1 && lat < 60) begin
            if (spam) begin
                op = 2'($urandom); a = $urandom; b = $urandom;
            end
            if (stall === 1'b1) stalls++;
            tick();
            lat++;
        end
        check("latency", 64'(lat), 64'(want));
        check("stall_cycles", 64'(stalls), 64'(want));
        check("done_stall", 64'(stall), 64'd0);
        check("hi", 64'(hi), 64'(eh));
        check("lo", 64'(lo), 64'(el));
        check("dbz", 64'(div_by_zero), 64'(ez));
        last_hi = eh;
        last_lo = el;
        tick();
        start = 1'b0;
        #1;
        check("done_pulse", 64'(done), 64'd0);
        check("after_stall", 64'(stall), 64'd0);
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] rx, ry;
        rst = 1'b1; start = 1'b0; flush = 1'b0; op = 2'd0; a = '0; b = '0;
        repeat (2) tick();
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_dbz", 64'(div_by_zero), 64'd0);
        check("rst_stall", 64'(stall), 64'd0);
        rst = 1'b0;
        tick();

        run_op(2'd0, 32'hFFFF_FFFD, 32'h0000_0007, 1'b0);
        run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op(2'd2, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0);
        run_op(2'd3, 32'hFFFF_FFFF, 32'h0000_0010, 1'b0);
        run_op(2'd2, 32'h1234_5678, 32'h0000_0000, 1'b0);
        run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op(2'd0, 32'h8000_0000, 32'h8000_0000, 1'b0);

        // DIVU annulled at T+10; a fresh op at T+12 must complete normally
        start = 1'b1; op = 2'd3; a = $urandom; b = $urandom | 32'h1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        check("flush_stall", 64'(stall), 64'd0);
        check("flush_done", 64'(done), 64'd0);
        check("flush_hi", 64'(hi), 64'(last_hi));
        check("flush_lo", 64'(lo), 64'(last_lo));
        tick();
        run_op(2'd3, 32'hDEAD_BEEF, 32'h0000_1234, 1'b0);

        // flush beats start in IDLE
        start = 1'b1; flush = 1'b1; op = 2'd1; a = 32'h5; b = 32'h6;
        tick();
        start = 1'b0; flush = 1'b0;
        #1;
        check("fs_stall", 64'(stall), 64'd0);
        repeat (3) tick();
        check("fs_done", 64'(done), 64'd0);
        check("fs_lo", 64'(lo), 64'(last_lo));

        run_op(2'd0, 32'h0001_2345, 32'hFFFF_F000, 1'b1);
        run_op(2'd2, 32'h7FFF_FFFF, 32'hFFFF_FFF0, 1'b1);

        for (int i = 0; i < 20; i++) begin
            ro = 2'($urandom);
            rx = $urandom;
            ry = $urandom;
            if ($urandom_range(0, 3) == 0) ry = $urandom_range(0, 40);
            if ($urandom_range(0, 4) == 0) rx = $urandom_range(0, 300);
            run_op(ro, rx, ry, 1'b0);
        end

        // reset in the middle of an iterative multiply
        start = 1'b1; op = 2'd0; a = $urandom; b = $urandom;
        tick();
        start = 1'b0;
        repeat (10) tick();
        rst = 1'b1;
        tick();
        check("mid_rst_hi", 64'(hi), 64'd0);
        check("mid_rst_lo", 64'(lo), 64'd0);
        check("mid_rst_done", 64'(done), 64'd0);
        check("mid_rst_dbz", 64'(div_by_zero), 64'd0);
        check("mid_rst_stall", 64'(stall), 64'd0);
        rst = 1'b0;
        last_hi = '0;
        last_lo = '0;
        tick();
        run_op(2'd1, 32'h0000_FFFF, 32'h0001_0001, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
